sparse_stream_sink: RTL

Synthesizable receiving end of the 17-bit ready/valid sparse token stream produced by the sparse primitives, such as the ref output of the repeat unit.
- Accepts tokens under a programmable backpressure pattern.
- Captures each accepted token into an internal buffer that can be read back.
- Classifies tokens as data, stop or done.
- Measures stream latency from the first valid beat to the done token.
- Used on-chip and in the unit-test harness as the hardware counterpart of the token transmitter.

---
 rtl/sparse_token_pkg.sv | 36 +++
 rtl/sink_capture_mem.sv | 42 ++++
 rtl/sink_protocol_chk.sv | 13 +
 rtl/sparse_stream_sink.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sparse_token_pkg.sv
// Shared definitions for the 17-bit sparse token stream: token classes,
// the fixed done/stop encodings and the sink FSM states.
package sparse_token_pkg;

    localparam int unsigned TOKEN_W = 17;
    localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;
    // Control flag set, level byte's upper neighbour cleared
    localparam logic [8:0] STOP_PREFIX = 9'h100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sink_state_e;

    function automatic logic is_ctrl(input logic [TOKEN_W-1:0] tok);
        return tok[TOKEN_W-1];
    endfunction

    function automatic logic is_done(input logic [TOKEN_W-1:0] tok);
        return (tok == DONE_TOKEN);
    endfunction

    function automatic logic is_stop(input logic [TOKEN_W-1:0] tok);
        return (tok[TOKEN_W-1:8] == STOP_PREFIX);
    endfunction

    function automatic logic [7:0] stop_level(input logic [TOKEN_W-1:0] tok);
        return tok[7:0];
    endfunction

    function automatic logic is_illegal(input logic [TOKEN_W-1:0] tok);
        return is_ctrl(tok) & ~is_stop(tok) & ~is_done(tok);
    endfunction

endpackage

// File: rtl/sink_capture_mem.sv
// Capture buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module sink_capture_mem #(
    parameter  int unsigned WIDTH = 17,
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Storage array write; contents survive reset and soft clear
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= '0;
        end else if (rd_clr) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sink_protocol_chk.sv
// Protocol checker for the sparse stream sink; carries assertions only.
module sink_protocol_chk (
    input logic clk,
    input logic rst,
    input logic in_done_state,
    input logic xfer
);

    // Once the done token is taken the sink never completes another handshake
    a_no_xfer_after_done: assert property (@(posedge clk) disable iff (rst)
        !(in_done_state && xfer));

endmodule

// File: rtl/sparse_stream_sink.sv
// Receiving end of the sparse token stream: patterned backpressure, token
// capture, token classification and first-valid-to-done latency measurement.
module sparse_stream_sink
    import sparse_token_pkg::*;
#(
    parameter  int unsigned DEPTH = 256,
    parameter  int unsigned PAT_W = 8,
    parameter  int unsigned CNT_W = 32,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned SW    = (PAT_W > 1) ? $clog2(PAT_W) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               flush,
    input  logic               tile_en,
    input  logic [TOKEN_W-1:0] data_in,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    input  logic [PAT_W-1:0]   stall_pattern,
    input  logic [AW-1:0]      rd_addr,
    output logic [TOKEN_W-1:0] rd_data,
    output logic [AW:0]        token_count,
    output logic [15:0]        stop_count,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               done,
    output logic               overflow,
    output logic               protocol_err
);

    localparam logic [AW:0]    DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]    TOK_ONE   = (AW+1)'(1'b1);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(PAT_W - 1);
    localparam logic [SW-1:0]  SLOT_ONE  = SW'(1'b1);
    localparam logic [CNT_W-1:0] CYC_ONE = CNT_W'(1'b1);

    sink_state_e        state_r;
    sink_state_e        state_nxt_s;
    logic [SW-1:0]      slot_r;
    logic [AW:0]        token_count_r;
    logic [15:0]        stop_count_r;
    logic [CNT_W-1:0]   cycle_count_r;
    logic               done_r;
    logic               overflow_r;
    logic               protocol_err_r;

    logic ready_s;
    logic xfer_s;
    logic start_s;
    logic count_en_s;
    logic buf_full_s;
    logic wr_en_s;
    logic tok_done_s;
    logic tok_stop_s;
    logic tok_bad_s;
    logic late_data_s;

    // Ready is a pure function of registered state and the enables, never of valid
    assign ready_s = clk_en & tile_en & ~flush & ~rst
                   & (state_r != DONE) & stall_pattern[slot_r];

    // Handshake qualification, token decode and next-state selection
    always_comb begin
        xfer_s      = data_in_valid & ready_s;
        tok_done_s  = is_done(data_in);
        tok_stop_s  = is_stop(data_in);
        tok_bad_s   = is_illegal(data_in);
        buf_full_s  = (token_count_r == DEPTH_C);
        wr_en_s     = xfer_s & ~buf_full_s;
        late_data_s = xfer_s & (state_r == DONE) & ~is_ctrl(data_in);
        start_s     = clk_en & tile_en & ~flush & data_in_valid & (state_r == IDLE);
        count_en_s  = clk_en & ~flush & (start_s | (state_r == RUN));

        state_nxt_s = state_r;
        if (!clk_en) begin
            state_nxt_s = state_r;
        end else if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s && tok_done_s) begin
                        state_nxt_s = DONE;
                    end else if (start_s) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RUN: begin
                    if (xfer_s && tok_done_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                DONE: begin
                    state_nxt_s = DONE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Backpressure rotation slot: free-running on every enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_r <= '0;
        end else if (clk_en) begin
            if (flush) begin
                slot_r <= '0;
            end else if (slot_r == SLOT_LAST) begin
                slot_r <= '0;
            end else begin
                slot_r <= slot_r + SLOT_ONE;
            end
        end
    end

    // Token/stop/cycle counters and sticky status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            token_count_r  <= '0;
            stop_count_r   <= '0;
            cycle_count_r  <= '0;
            done_r         <= 1'b0;
            overflow_r     <= 1'b0;
            protocol_err_r <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                token_count_r  <= '0;
                stop_count_r   <= '0;
                cycle_count_r  <= '0;
                done_r         <= 1'b0;
                overflow_r     <= 1'b0;
                protocol_err_r <= 1'b0;
            end else begin
                if (wr_en_s) begin
                    token_count_r <= token_count_r + TOK_ONE;
                end
                if (xfer_s && tok_stop_s) begin
                    stop_count_r <= stop_count_r + 16'd1;
                end
                // Latency counter sticks at all-ones rather than wrapping
                if (count_en_s && (cycle_count_r != '1)) begin
                    cycle_count_r <= cycle_count_r + CYC_ONE;
                end
                if (xfer_s && tok_done_s) begin
                    done_r <= 1'b1;
                end
                if (xfer_s && buf_full_s) begin
                    overflow_r <= 1'b1;
                end
                if ((xfer_s && tok_bad_s) || late_data_s) begin
                    protocol_err_r <= 1'b1;
                end
            end
        end
    end

    sink_capture_mem #(
        .WIDTH (TOKEN_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (clk_en & ~flush),
        .rd_clr  (clk_en & flush),
        .wr_en   (wr_en_s),
        .wr_addr (token_count_r[AW-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    sink_protocol_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .in_done_state (state_r == DONE),
        .xfer          (xfer_s)
    );

    assign data_in_ready = ready_s;
    assign token_count   = token_count_r;
    assign stop_count    = stop_count_r;
    assign cycle_count   = cycle_count_r;
    assign done          = done_r;
    assign overflow      = overflow_r;
    assign protocol_err  = protocol_err_r;

endmodule
